// File: rtl/booth_mul_pkg.sv
// Shared widths, FSM state and Booth digit types for the radix-4 multiplier.
// Holds the triplet-to-digit decode used by the partial-product generator.
package booth_mul_pkg;

    localparam int OP_W  = 33;
    localparam int RES_W = 64;
    localparam int STEPS = 17;
    localparam int CNT_W = 5;
    localparam int Y_W   = OP_W + 2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    function automatic digit_t booth_digit(input logic [2:0] triplet);
        digit_t d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mul_if.sv
// Operand/result handshake bundle between the ALU and the Booth multiplier.
// The master offers operands under in_valid/in_ready and reads result under out_valid.
interface booth_mul_if;
    import booth_mul_pkg::*;

    logic [OP_W-1:0]  src1;
    logic [OP_W-1:0]  src2;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic [RES_W-1:0] result;

    modport master (
        output src1, src2, in_valid,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  src1, src2, in_valid,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product generator: combinational, zero latency, no handshake.
// Produces digit*X (unshifted) from one recoding triplet.
module booth_r4_pp
    import booth_mul_pkg::*;
(
    input  logic [2:0]       triplet,
    input  logic [RES_W-1:0] x,
    output logic [RES_W-1:0] pp
);

    digit_t           digit;
    logic [RES_W-1:0] mag;
    logic             neg;

    always_comb begin
        digit = booth_digit(triplet);
        mag   = '0;
        neg   = 1'b0;
        case (digit)
            POS1: mag = x;
            POS2: mag = x << 1;
            NEG1: begin
                mag = x;
                neg = 1'b1;
            end
            NEG2: begin
                mag = x << 1;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp = neg ? (~mag + RES_W'(1)) : mag;
    end

endmodule

// File: rtl/booth_mul.sv
// Iterative radix-4 Booth multiplier, 33x33 -> low 64 bits; 17 BUSY cycles per product.
// Single op in flight: in_ready is low while BUSY, and out_valid pulses in DONE until the next accept.
module booth_mul
    import booth_mul_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    booth_mul_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_step;
    logic [Y_W-1:0]   y_q;
    logic [RES_W-1:0] x_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] pp;
    logic [RES_W-1:0] pp_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_step = (cnt_q == LAST_STEP);

    always_comb begin
        state_d      = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                bus.in_ready  = 1'b1;
                bus.out_valid = 1'b1;
                accept        = bus.in_valid;
                if (accept) state_d = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    // y_q shifts right two places per step, so the live triplet is always y_q[2:0].
    booth_r4_pp u_pp (
        .triplet (y_q[2:0]),
        .x       (x_q),
        .pp      (pp)
    );

    assign pp_sh = pp << {cnt_q, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q   <= '0;
            x_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            y_q   <= {bus.src1[OP_W-1], bus.src1, 1'b0};
            x_q   <= {{(RES_W-OP_W){bus.src2[OP_W-1]}}, bus.src2};
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            y_q   <= y_q >> 2;
            acc_q <= acc_q + pp_sh;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) res_q <= acc_q + pp_sh;
        end
    end

    assign bus.result = res_q;

endmodule

// File: tb/tb_booth_mul.sv
// Directed and random bench for booth_mul against a plain signed-multiply reference.
module tb_booth_mul;
    import booth_mul_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    int               checks = 0;
    int               errors = 0;
    logic [RES_W-1:0] prev_res;
    logic [OP_W-1:0]  pa [0:12];
    logic [OP_W-1:0]  pb [0:12];
    logic [OP_W-1:0]  ta;
    logic [OP_W-1:0]  tb;

    booth_mul_if bif ();

    booth_mul u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [32:0] a, input logic [32:0] b);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = {{33{a[32]}}, a};
        sb = {{33{b[32]}}, b};
        p  = sa * sb;
        return p[63:0];
    endfunction

    function automatic logic [32:0] rand_op();
        logic [31:0] r;
        logic        sgn;
        r   = $urandom;
        sgn = 1'($urandom_range(0, 1));
        return {sgn & r[31], r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT ready; returns at the DONE negedge.
    task automatic run_op(input string tag,
                          input logic [32:0] a, input logic [32:0] b,
                          input logic [32:0] na, input logic [32:0] nb,
                          input bit hold, input bit toggle,
                          input logic [63:0] exp);
        int bad;
        bad = 0;
        bif.src1     = a;
        bif.src2     = b;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            bif.src1 = na;
            bif.src2 = nb;
        end else begin
            bif.in_valid = 1'b0;
        end
        for (int k = 1; k <= STEPS; k++) begin
            @(negedge clk);
            if (bif.in_ready !== 1'b0 || bif.out_valid !== 1'b0) bad++;
            if (k == 1) check({tag, ":held_result"}, bif.result, prev_res);
            if (toggle) begin
                bif.src1     = rand_op();
                bif.src2     = rand_op();
                bif.in_valid = (k < STEPS) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        check({tag, ":busy_flags_bad_cycles"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, ":out_valid"}, 64'(bif.out_valid), 64'd1);
        check({tag, ":in_ready"}, 64'(bif.in_ready), 64'd1);
        check({tag, ":result"}, bif.result, exp);
        prev_res = exp;
    endtask

    initial begin
        reset        = 1'b1;
        bif.in_valid = 1'b0;
        bif.src1     = '0;
        bif.src2     = '0;
        prev_res     = '0;

        repeat (2) @(negedge clk);
        check("rst:in_ready", 64'(bif.in_ready), 64'd1);
        check("rst:out_valid", 64'(bif.out_valid), 64'd0);
        check("rst:result", bif.result, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle:in_ready", 64'(bif.in_ready), 64'd1);
        check("idle:out_valid", 64'(bif.out_valid), 64'd0);

        run_op("umax", {1'b0, 32'hFFFFFFFF}, {1'b0, 32'hFFFFFFFF}, '0, '0, 1'b0, 1'b0,
               64'hFFFFFFFE00000001);
        run_op("neg1sq", {1'b1, 32'hFFFFFFFF}, {1'b1, 32'hFFFFFFFF}, '0, '0, 1'b0, 1'b0,
               64'h1);
        run_op("minsq", {1'b1, 32'h80000000}, {1'b1, 32'h80000000}, '0, '0, 1'b0, 1'b0,
               64'h4000000000000000);
        run_op("m2x3", {1'b1, 32'hFFFFFFFE}, 33'd3, '0, '0, 1'b0, 1'b0,
               64'hFFFFFFFFFFFFFFFA);
        run_op("zero", 33'd0, rand_op(), '0, '0, 1'b0, 1'b0, 64'h0);

        ta = rand_op();
        tb = rand_op();
        run_op("toggle", ta, tb, '0, '0, 1'b0, 1'b1, ref_mul(ta, tb));

        for (int j = 0; j <= 12; j++) begin
            pa[j] = rand_op();
            pb[j] = rand_op();
        end
        for (int j = 0; j < 12; j++) begin
            run_op("b2b", pa[j], pb[j], pa[j+1], pb[j+1], (j < 11), 1'b0,
                   ref_mul(pa[j], pb[j]));
        end

        ta = rand_op();
        tb = rand_op();
        bif.src1     = ta;
        bif.src2     = tb;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort:in_ready", 64'(bif.in_ready), 64'd1);
        check("abort:out_valid", 64'(bif.out_valid), 64'd0);
        check("abort:result", bif.result, 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        prev_res = '0;
        @(negedge clk);
        check("abort:idle_out_valid", 64'(bif.out_valid), 64'd0);
        ta = rand_op();
        tb = rand_op();
        run_op("post_abort", ta, tb, '0, '0, 1'b0, 1'b0, ref_mul(ta, tb));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
